// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the receive FIFO and the transmitter.
package uart_pkg;

  localparam int unsigned DataBitsDefault = 8;

  typedef logic [7:0] uart_byte_t;

  // Saturating 8-bit increment, used for event counters that must stick at 255.
  function automatic logic [7:0] satInc8(logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver/consumer side and the receive FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DataBitsDefault,
  parameter int unsigned DEPTH     = 16
) ();

  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic                 RxReady;
  logic [DATA_BITS-1:0] RxData;
  logic                 RdReq;
  logic                 ClearOverflow;
  logic [DATA_BITS-1:0] RdData;
  logic                 Empty;
  logic                 Full;
  logic                 AlmostFull;
  logic [CountW-1:0]    Count;
  logic                 Overflow;
  logic [7:0]           DropCount;

  modport master (
    output RxReady, RxData, RdReq, ClearOverflow,
    input  RdData, Empty, Full, AlmostFull, Count, Overflow, DropCount
  );

  modport slave (
    input  RxReady, RxData, RdReq, ClearOverflow,
    output RdData, Empty, Full, AlmostFull, Count, Overflow, DropCount
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read, asynchronous clear.
module uart_fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             WrEn,
  input  logic [AddrW-1:0] WrAddr,
  input  logic [Width-1:0] WrData,
  input  logic [AddrW-1:0] RdAddr,
  output logic [Width-1:0] RdData
);

  logic [Width-1:0] memQ [Depth];

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      memQ <= '{default: '0};
    end else if (WrEn) begin
      memQ[WrAddr] <= WrData;
    end
  end

  assign RdData = memQ[RdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with level flags and sticky overflow accounting.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS         = DataBitsDefault,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input logic          Clock,
  input logic          ResetN,
  uart_rx_fifo_if.slave Bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CountW = AddrW + 1;
  localparam logic [CountW-1:0] DepthLevel = CountW'(DEPTH);
  localparam logic [CountW-1:0] AfLevel = CountW'(ALMOST_FULL_LEVEL);

  logic [AddrW-1:0]     wrPtrQ, rdPtrQ;
  logic [CountW-1:0]    countQ;
  logic                 overflowQ;
  logic [7:0]           dropCountQ;
  logic                 empty, full;
  logic                 wrEn, rdEn, drop;
  logic [DATA_BITS-1:0] headData;

  assign empty = (countQ == '0);
  assign full  = (countQ == DepthLevel);

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign wrEn = Bus.RxReady & (~full | Bus.RdReq);
  assign rdEn = Bus.RdReq & ~empty;
  assign drop = Bus.RxReady & full & ~Bus.RdReq;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      countQ     <= '0;
      overflowQ  <= 1'b0;
      dropCountQ <= '0;
    end else begin
      if (wrEn) begin
        wrPtrQ <= wrPtrQ + AddrW'(1);
      end
      if (rdEn) begin
        rdPtrQ <= rdPtrQ + AddrW'(1);
      end

      unique case ({wrEn, rdEn})
        2'b10:   countQ <= countQ + CountW'(1);
        2'b01:   countQ <= countQ - CountW'(1);
        default: countQ <= countQ;
      endcase

      // A drop in the same cycle as a clear restarts the tally at one.
      if (drop) begin
        overflowQ  <= 1'b1;
        dropCountQ <= Bus.ClearOverflow ? 8'd1 : satInc8(dropCountQ);
      end else if (Bus.ClearOverflow) begin
        overflowQ  <= 1'b0;
        dropCountQ <= '0;
      end
    end
  end

  uart_fifo_mem #(
    .Width (DATA_BITS),
    .Depth (DEPTH)
  ) u_mem (
    .Clock  (Clock),
    .ResetN (ResetN),
    .WrEn   (wrEn),
    .WrAddr (wrPtrQ),
    .WrData (Bus.RxData),
    .RdAddr (rdPtrQ),
    .RdData (headData)
  );

  assign Bus.RdData     = headData;
  assign Bus.Empty      = empty;
  assign Bus.Full       = full;
  assign Bus.AlmostFull = (countQ >= AfLevel);
  assign Bus.Count      = countQ;
  assign Bus.Overflow   = overflowQ;
  assign Bus.DropCount  = dropCountQ;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo against a queue-based model, plus directed literal checks.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned Depth   = 16;
  localparam int unsigned AfLevel = 12;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   cmpEn    = 1'b0;

  uart_byte_t modelQ[$];
  bit         modelOvf;
  int         modelDrops;

  always #10 Clock = ~Clock;

  uart_rx_fifo_if #(.DATA_BITS(8), .DEPTH(Depth)) bus ();

  uart_rx_fifo #(
    .DATA_BITS         (8),
    .DEPTH             (Depth),
    .ALMOST_FULL_LEVEL (AfLevel)
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Bus    (bus)
  );

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a byte queue with drop accounting, cleared asynchronously.
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      modelQ.delete();
      modelOvf   = 1'b0;
      modelDrops = 0;
    end else begin
      bit isFull, doWr, doRd, doDrop;
      isFull = (modelQ.size() == Depth);
      doRd   = bus.RdReq && (modelQ.size() != 0);
      doWr   = bus.RxReady && (!isFull || bus.RdReq);
      doDrop = bus.RxReady && isFull && !bus.RdReq;
      if (doRd) void'(modelQ.pop_front());
      if (doWr) modelQ.push_back(bus.RxData);
      if (doDrop) begin
        modelOvf   = 1'b1;
        modelDrops = bus.ClearOverflow ? 1 : ((modelDrops < 255) ? modelDrops + 1 : 255);
      end else if (bus.ClearOverflow) begin
        modelOvf   = 1'b0;
        modelDrops = 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (ResetN && cmpEn) begin
      check("cmp_count", int'(bus.Count), modelQ.size());
      check("cmp_empty", int'(bus.Empty), int'(modelQ.size() == 0));
      check("cmp_full", int'(bus.Full), int'(modelQ.size() == Depth));
      check("cmp_afull", int'(bus.AlmostFull), int'(modelQ.size() >= AfLevel));
      check("cmp_ovf", int'(bus.Overflow), int'(modelOvf));
      check("cmp_drops", int'(bus.DropCount), modelDrops);
      if (modelQ.size() != 0) check("cmp_rddata", int'(bus.RdData), int'(modelQ[0]));
    end
  end

  task automatic cyc(input bit rx, input logic [7:0] d, input bit rd, input bit clr);
    bus.RxReady       = rx;
    bus.RxData        = d;
    bus.RdReq         = rd;
    bus.ClearOverflow = clr;
    @(posedge Clock);
    #1;
    bus.RxReady       = 1'b0;
    bus.RdReq         = 1'b0;
    bus.ClearOverflow = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_count"}, int'(bus.Count), 0);
    check({tag, "_empty"}, int'(bus.Empty), 1);
    check({tag, "_full"}, int'(bus.Full), 0);
    check({tag, "_afull"}, int'(bus.AlmostFull), 0);
    check({tag, "_ovf"}, int'(bus.Overflow), 0);
    check({tag, "_drops"}, int'(bus.DropCount), 0);
    check({tag, "_rddata"}, int'(bus.RdData), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int occ;
    int pushed;
    int popped;
    bus.RxReady       = 1'b0;
    bus.RxData        = '0;
    bus.RdReq         = 1'b0;
    bus.ClearOverflow = 1'b0;

    #25;
    checkResetState("reset");
    ResetN = 1'b1;
    cmpEn  = 1'b1;
    @(posedge Clock);
    #1;

    // Three writes then three pops.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    check("t1_count", int'(bus.Count), 3);
    check("t1_head", int'(bus.RdData), 8'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_pop1", int'(bus.RdData), 8'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_pop2", int'(bus.RdData), 8'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_empty", int'(bus.Empty), 1);

    // Fill to full, flag thresholds, one drop, ordered drain.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) check("t2_afull_lo", int'(bus.AlmostFull), 0);
      if (i == 11) check("t2_afull_hi", int'(bus.AlmostFull), 1);
      if (i == 14) check("t2_full_lo", int'(bus.Full), 0);
      if (i == 15) check("t2_full_hi", int'(bus.Full), 1);
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    check("t2_ovf", int'(bus.Overflow), 1);
    check("t2_drops", int'(bus.DropCount), 1);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", int'(bus.RdData), i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("t2_empty", int'(bus.Empty), 1);

    // Simultaneous write and pop while full.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("t3_count", int'(bus.Count), 16);
    check("t3_drops", int'(bus.DropCount), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t3_last", int'(bus.RdData), 8'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Saturating drop counter and clear-versus-drop priority.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    repeat (300) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("t4_sat", int'(bus.DropCount), 255);
    check("t4_ovf", int'(bus.Overflow), 1);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    check("t4_clr_drop_ovf", int'(bus.Overflow), 1);
    check("t4_clr_drop_cnt", int'(bus.DropCount), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_clr_ovf", int'(bus.Overflow), 0);
    check("t4_clr_cnt", int'(bus.DropCount), 0);
    repeat (16) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap with occupancy held between 1 and 3.
    occ    = 1;
    pushed = 1;
    popped = 0;
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    while (pushed < 40) begin
      bit doPush, doPop;
      doPush = (occ < 3) && ($urandom_range(0, 1) == 1);
      doPop  = (occ > 1) && ($urandom_range(0, 1) == 1);
      if (!doPush && !doPop) begin
        doPush = 1'b1;
        doPop  = 1'b1;
      end
      if (doPop) begin
        check("t5_order", int'(bus.RdData), 8'h40 + popped);
        popped++;
      end
      cyc(doPush, 8'(8'h40 + pushed), doPop, 1'b0);
      if (doPush) pushed++;
      occ = pushed - popped;
    end
    while (popped < 40) begin
      check("t5_order", int'(bus.RdData), 8'h40 + popped);
      popped++;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("t5_empty", int'(bus.Empty), 1);

    // Random traffic against the model.
    repeat (1500) begin
      cyc(($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
    end
    repeat (20) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, leaving a sticky overflow to be cleared by it.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hDD, 1'b0, 1'b0);
    repeat (11) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_pre_count", int'(bus.Count), 5);
    #3;
    ResetN = 1'b0;
    #1;
    checkResetState("t6_async");
    @(posedge Clock);
    #4;
    ResetN = 1'b1;
    @(posedge Clock);
    #1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    check("t6_post_head", int'(bus.RdData), 8'h5A);
    check("t6_post_count", int'(bus.Count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
